// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one external memory port between the instruction
// fetch requester (read-only) and the MEM-stage data requester (read/write).
// Optional ack watchdog is compiled in with the ARB_TIMEOUT_EN macro.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W       = 64,
    parameter int unsigned DATA_W       = 64,
    parameter int unsigned MAX_D_STREAK = 4,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req_i,
    input  logic [ADDR_W-1:0]   i_addr_i,
    input  logic                i_kill_i,
    output logic                i_done_o,
    output logic [DATA_W-1:0]   i_rdata_o,
    input  logic                d_req_i,
    input  logic                d_we_i,
    input  logic [ADDR_W-1:0]   d_addr_i,
    input  logic [DATA_W-1:0]   d_wdata_i,
    input  logic [DATA_W/8-1:0] d_wstrb_i,
    output logic                d_done_o,
    output logic [DATA_W-1:0]   d_rdata_o,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W/8-1:0] mem_wstrb_o,
    input  logic                mem_ack_i,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    output logic                mem_err_o,
    output logic                stall_if_o,
    output logic                stall_mem_o
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned SK_W   = $clog2(MAX_D_STREAK + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_BUSY_I = 2'd1;
    localparam logic [1:0] ST_BUSY_D = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    logic [1:0]        state_q,  state_d;
    logic              req_q,    req_d;
    logic              we_q,     we_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [DATA_W-1:0] wdata_q,  wdata_d;
    logic [STRB_W-1:0] wstrb_q,  wstrb_d;
    logic [SK_W-1:0]   streak_q, streak_d;
    logic              kill_q,   kill_d;
    logic              i_done_q, i_done_d;
    logic              d_done_q, d_done_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    logic              fetch_ok_c;
    logic              streak_full_c;
    logic              timeout_hit_c;
    logic [DATA_W-1:0] fin_data_c;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned TO_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [TO_W-1:0] to_q, to_d;
    logic            err_q, err_d;

    // Watchdog: count un-acked BUSY cycles, cleared while idle so it starts at 0 in BUSY
    always_comb begin
        to_d          = to_q;
        err_d         = err_q;
        timeout_hit_c = 1'b0;
        if ((state_q == ST_BUSY_I) || (state_q == ST_BUSY_D)) begin
            if (!mem_ack_i) begin
                if (to_q == TO_W'(TIMEOUT - 1)) begin
                    timeout_hit_c = 1'b1;
                    err_d         = 1'b1;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
        end else begin
            to_d = '0;
        end
    end

    // Watchdog registers; error flag is sticky until reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            to_q  <= '0;
            err_q <= 1'b0;
        end else begin
            to_q  <= to_d;
            err_q <= err_d;
        end
    end

    assign mem_err_o = err_q;
`else
    assign timeout_hit_c = 1'b0;
    assign mem_err_o     = 1'b0;
`endif

    // Arbitration, transaction sequencing and response capture
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        streak_d  = streak_q;
        kill_d    = kill_q;
        i_done_d  = 1'b0;
        d_done_d  = 1'b0;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;

        fetch_ok_c    = i_req_i & ~i_kill_i;
        streak_full_c = (streak_q == SK_W'(MAX_D_STREAK));
        fin_data_c    = mem_ack_i ? mem_rdata_i : '0;

        case (state_q)
            ST_IDLE: begin
                if (d_req_i && !(fetch_ok_c && streak_full_c)) begin
                    state_d = ST_BUSY_D;
                    req_d   = 1'b1;
                    we_d    = d_we_i;
                    addr_d  = d_addr_i;
                    wdata_d = d_wdata_i;
                    wstrb_d = d_wstrb_i;
                    kill_d  = 1'b0;
                    if (i_req_i) begin
                        streak_d = streak_full_c ? streak_q : streak_q + SK_W'(1);
                    end else begin
                        streak_d = '0;
                    end
                end else if (fetch_ok_c) begin
                    state_d  = ST_BUSY_I;
                    req_d    = 1'b1;
                    we_d     = 1'b0;
                    addr_d   = i_addr_i;
                    wdata_d  = '0;
                    wstrb_d  = '0;
                    kill_d   = i_kill_i;
                    streak_d = '0;
                end
            end
            ST_BUSY_I, ST_BUSY_D: begin
                kill_d = kill_q | ((state_q == ST_BUSY_I) & i_kill_i);
                if (mem_ack_i || timeout_hit_c) begin
                    state_d = ST_RESP;
                    req_d   = 1'b0;
                    if (state_q == ST_BUSY_I) begin
                        if (!kill_d) begin
                            i_done_d  = 1'b1;
                            i_rdata_d = fin_data_c;
                        end
                    end else begin
                        d_done_d  = 1'b1;
                        d_rdata_d = fin_data_c;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                kill_d  = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            streak_q  <= '0;
            kill_q    <= 1'b0;
            i_done_q  <= 1'b0;
            d_done_q  <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            streak_q  <= streak_d;
            kill_q    <= kill_d;
            i_done_q  <= i_done_d;
            d_done_q  <= d_done_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    assign mem_req_o   = req_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign mem_wstrb_o = wstrb_q;
    assign i_done_o    = i_done_q;
    assign d_done_o    = d_done_q;
    assign i_rdata_o   = i_rdata_q;
    assign d_rdata_o   = d_rdata_q;

    // Pipeline stall requests are combinational so the done cycle releases the stage
    assign stall_if_o  = i_req_i & ~i_done_q & ~i_kill_i;
    assign stall_mem_o = d_req_i & ~d_done_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single external memory port between the instruction-fetch requester (icache refill, read-only) and the MEM-stage data requester (read/write).
- Sequences each transaction through a small FSM and drives stall requests (stall_if_o, stall_mem_o) into the pipeline controller.
- Honours branch-kill of an in-flight fetch.

Parameters:
- ADDR_W, 64, address width (matches AddrBus).
- DATA_W, 64, data width.
- MAX_D_STREAK, 4, consecutive data grants allowed while a fetch waits; the next grant then goes to fetch.
- TIMEOUT, 255, ack watchdog limit in cycles (used only with ARB_TIMEOUT_EN).

Ports:
- clk  input  1  clock; all logic rising-edge.
- rst  input  1  reset; synchronous, active-low.
- i_req_i  input  1  fetch request; held until i_done_o or killed.
- i_addr_i  input  ADDR_W  fetch address; stable while i_req_i is high.
- i_kill_i  input  1  branch flush from the controller; cancels the fetch.
- i_done_o  output  1  one-cycle pulse; i_rdata_o is valid.
- i_rdata_o  output  DATA_W  fetch read data.
- d_req_i  input  1  data request; held until d_done_o.
- d_we_i  input  1  1 = write, 0 = read.
- d_addr_i  input  ADDR_W  data address.
- d_wdata_i  input  DATA_W  write data.
- d_wstrb_i  input  DATA_W/8  byte strobes.
- d_done_o  output  1  one-cycle pulse; d_rdata_o is valid for reads.
- d_rdata_o  output  DATA_W  data read data.
- mem_req_o  output  1  downstream request; held until mem_ack_i.
- mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o  output  1/ADDR_W/DATA_W/DATA_W/8  latched transaction fields.
- mem_ack_i  input  1  downstream completion; mem_rdata_i is valid in the same cycle.
- mem_rdata_i  input  DATA_W  downstream read data.
- mem_err_o  output  1  sticky timeout flag (tied 0 without ARB_TIMEOUT_EN).
- stall_if_o  output  1  combinational: i_req_i & ~i_done_o & ~i_kill_i.
- stall_mem_o  output  1  combinational: d_req_i & ~d_done_o.

Behaviour:
- Reset (rst = 0 at a clock edge):
  - State goes to IDLE.
  - All registered outputs, the latched fields, the streak counter, the kill flag and mem_err_o go to 0.
  - Reset mid-transaction abandons the transaction. There is no done pulse. mem_req_o is 0 in the cycle after the reset edge.
- States: IDLE, BUSY_I, BUSY_D, RESP.
- IDLE:
  - Samples the requests; a fetch request is eligible only if i_kill_i = 0.
  - Data request only: grant D.
  - Fetch request only: grant I.
  - Both requests: grant D, unless streak == MAX_D_STREAK, in which case grant I.
  - On a grant, latch addr/we/wdata/wstrb (a fetch forces we = 0 and wstrb = 0) and go to BUSY_x.
  - mem_req_o = 1 from the next cycle.
- Streak counter:
  - Increments on each D grant made while i_req_i = 1, saturating at MAX_D_STREAK.
  - Clears on any I grant, or on a D grant made with i_req_i = 0.
- BUSY_x:
  - mem_req_o = 1 and the latched fields are stable.
  - On mem_ack_i = 1: capture mem_rdata_i into the owner's rdata register, deassert mem_req_o next cycle, go to RESP.
  - An ack in the first BUSY cycle is legal.
- Kill:
  - i_kill_i = 1 in BUSY_I, or on the grant cycle, sets the kill flag.
  - On ack: go to RESP but suppress i_done_o, and leave i_rdata_o unchanged.
  - The kill flag clears in RESP.
- RESP: pulse the owner's done for exactly 1 cycle (i_done_o suppressed if killed), then go to IDLE.
- Requester rule: on the cycle after done, the requester drops req or presents the next request. IDLE re-samples one cycle after RESP.
- Latency: minimum 4 cycles from req to re-arbitration.
  - Cycle 0: grant.
  - Cycle 1: mem_req_o high, ack earliest.
  - Cycle 2: done.
  - Cycle 3: IDLE.
- mem_ack_i outside BUSY is ignored.
- i_done_o and d_done_o are never high in the same cycle.
- The rdata outputs hold their last value between transactions.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit+ counter counts cycles in BUSY_x without an ack.
  - When it reaches TIMEOUT: force RESP, set mem_err_o (sticky until reset), pulse done with rdata = 0, drop mem_req_o.
  - The counter clears on entering BUSY.
- Undefined: no counter; BUSY waits indefinitely; mem_err_o is constant 0.

Test Plan:
- Single data write: d_req_i = 1, we = 1, addr = 0x8000_0010, wdata = 0xDEAD_BEEF_0123_4567, wstrb = 0xFF, ack on 1st BUSY cycle -> mem_* fields match at cycle 1; d_done_o pulses at cycle 2; stall_mem_o falls at cycle 2.
- Simultaneous requests: i_req_i and d_req_i asserted together, ack after 2 cycles -> D served first; I is granted at the next IDLE; i_rdata_o = mem_rdata_i value 0x0000_0013_0000_0093.
- Starvation guard: d_req_i re-asserted back-to-back for 6 transactions with i_req_i held, MAX_D_STREAK = 4 -> grant order is D, D, D, D, I, then D.
- Branch kill: fetch granted, i_kill_i = 1 in BUSY_I, ack 3 cycles later -> no i_done_o pulse; i_rdata_o unchanged; stall_if_o = 0 while killed; a pending d_req_i is granted at the next IDLE.
- Reset mid-transaction: rst = 0 during BUSY_D -> next cycle mem_req_o = 0 and all done/rdata outputs = 0; a later ack is ignored.
- ARB_TIMEOUT_EN with TIMEOUT = 8: no ack -> after 8 BUSY cycles, done pulses with rdata = 0; mem_err_o = 1 and stays 1 until reset.
